e15_core_p: RTL and testbench

- Parametrised successor to the team's 4-bit E15 processor: generic data width, register count and program depth.
- Adds a writable program memory loaded over a port, start/halt control, a carry flag with a jc branch, a two-state fetch/execute sequencer and a retired-instruction counter.
- Standalone teaching core; the bench drives the program port and observes results through the debug port.

---
 rtl/e15_core_p.sv | 142 ++++++++++++++
 tb/tb_e15_core_p.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/e15_core_p.sv
// e15_core_p: parametrised teaching core with loadable program memory,
// two-state fetch/execute sequencer, zero/carry flags and a saturating
// retired-instruction counter.
module e15_core_p #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2,
    parameter int PC_W   = 5,
    parameter int CNT_W  = 16,
    localparam int IW    = 4 + 2*REG_AW + DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [IW-1:0]     prog_wdata,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [PC_W-1:0]   pc,
    output logic              zflag,
    output logic              cflag,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [3:0] OP_JMP  = 4'b0000;
    localparam logic [3:0] OP_HALT = 4'b0001;
    localparam logic [3:0] OP_JZ   = 4'b0010;
    localparam logic [3:0] OP_JNZ  = 4'b0011;
    localparam logic [3:0] OP_JC   = 4'b0100;

    state_t state, stateNext;

    logic [IW-1:0]     progMem [2**PC_W];
    logic [DATA_W-1:0] regs [2**REG_AW];
    logic [IW-1:0]     ir;

    logic [3:0]        op;
    logic [REG_AW-1:0] src, dst;
    logic [DATA_W-1:0] imm, operand, wrData;
    logic [DATA_W:0]   addend, sum;
    logic [PC_W-1:0]   immPc, pcNext;
    logic              idleOrHalt, isSub, isArith, isWrite, isMove, taken;

    assign op  = ir[IW-1 -: 4];
    assign src = ir[IW-5 -: REG_AW];
    assign dst = ir[IW-5-REG_AW -: REG_AW];
    assign imm = ir[DATA_W-1:0];

    // Jump offset is the immediate truncated or zero-extended to pc width.
    if (DATA_W >= PC_W) begin : gImmTrunc
        assign immPc = imm[PC_W-1:0];
    end else begin : gImmExt
        assign immPc = {{(PC_W-DATA_W){1'b0}}, imm};
    end

    assign idleOrHalt = (state == IDLE) || (state == HALT);
    assign busy       = (state == FETCH) || (state == EXEC);
    assign halted     = (state == HALT);
    assign dbg_rdata  = regs[dbg_raddr];

    // Decode, ALU and next-pc for the instruction held in ir.
    always_comb begin
        operand = op[0] ? imm : regs[src];
        isSub   = (op[3:2] == 2'b11);                  // sub/subi/cmp/cmpi
        isArith = op[3] && (op[2] || op[1]);           // add..cmpi update flags
        isMove  = (op[3:1] == 3'b100);                 // mov/movi
        isWrite = op[3] && !(op[2] && op[1]);          // mov..subi write dst
        addend  = isSub ? {1'b0, ~operand} : {1'b0, operand};
        sum     = {1'b0, regs[dst]} + addend + {{DATA_W{1'b0}}, isSub};
        wrData  = isMove ? operand : sum[DATA_W-1:0];
        taken   = (op == OP_JMP) || (op == OP_JZ && zflag) ||
                  (op == OP_JNZ && !zflag) || (op == OP_JC && cflag);
        if (taken)
            pcNext = pc + immPc;
        else if (op == OP_HALT)
            pcNext = pc;
        else
            pcNext = pc + PC_W'(1);
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Sequencer next state; start is only honoured when not busy.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE, HALT: if (start) stateNext = FETCH;
            FETCH:      stateNext = EXEC;
            EXEC:       stateNext = (op == OP_HALT) ? HALT : FETCH;
            default:    stateNext = IDLE;
        endcase
    end

    // Program memory is not reset so a loaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (prog_we && idleOrHalt)
            progMem[prog_addr] <= prog_wdata;
    end

    // Architectural state: pc, flags, registers, ir and retired counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            zflag   <= 1'b0;
            cflag   <= 1'b0;
            retired <= '0;
            ir      <= '0;
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        pc      <= '0;
                        zflag   <= 1'b0;
                        cflag   <= 1'b0;
                        retired <= '0;
                    end
                end
                FETCH: ir <= progMem[pc];
                EXEC: begin
                    pc <= pcNext;
                    if (retired != '1) retired <= retired + CNT_W'(1);
                    if (isWrite) regs[dst] <= wrData;
                    if (isArith) begin
                        zflag <= (sum[DATA_W-1:0] == '0);
                        cflag <= sum[DATA_W];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_e15_core_p.sv
// Directed bench for e15_core_p: table of small programs with hand-computed
// final state, plus sequences for busy-time writes, mid-EXEC reset and wrap.
module tb_e15_core_p;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [15:0] prog_wdata = '0;
    logic [1:0]  dbg_raddr = '0;
    logic [7:0]  dbg_rdata, dbgS;
    logic [4:0]  pc, pcS;
    logic        zflag, cflag, busy, halted, zS, cS, busyS, haltedS;
    logic [15:0] retired;
    logic [3:0]  retiredS;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    e15_core_p dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata), .pc(pc), .zflag(zflag), .cflag(cflag),
        .busy(busy), .halted(halted), .retired(retired)
    );

    // Narrow-counter copy sharing all inputs, used for saturation.
    e15_core_p #(.CNT_W(4)) dutS (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbgS), .pc(pcS), .zflag(zS), .cflag(cS),
        .busy(busyS), .halted(haltedS), .retired(retiredS)
    );

    typedef struct {
        logic [7:0][15:0] prog;
        logic [3:0][7:0]  r;
        logic             z;
        logic             c;
        logic [4:0]       pc;
        logic [15:0]      ret;
    } vec_t;

    vec_t v[7];

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] s,
                                        input logic [1:0] d, input logic [7:0] imm);
        return {op, s, d, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load(input logic [7:0][15:0] p);
        for (int k = 0; k < 8; k++) begin
            prog_we = 1'b1; prog_addr = 5'(k); prog_wdata = p[k];
            tick();
        end
        prog_we = 1'b0;
    endtask

    // Waits for halted; n = posedges after the start edge.
    task automatic waitHalt(inout int n);
        while (!halted && n < 300) begin
            tick();
            n++;
        end
        chk("halt_timeout", halted, 1'b1);
    endtask

    task automatic checkResult(input string tag, input vec_t e, input int n);
        for (int k = 0; k < 4; k++) begin
            dbg_raddr = 2'(k);
            #1;
            chk($sformatf("%s_r%0d", tag, k), dbg_rdata, e.r[k]);
        end
        chk({tag, "_z"}, zflag, e.z);
        chk({tag, "_c"}, cflag, e.c);
        chk({tag, "_pc"}, pc, e.pc);
        chk({tag, "_retired"}, retired, e.ret);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_cycles"}, n, 2 * e.ret);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 8; k++) v[i].prog[k] = 16'h1000;
            v[i].r = '0;
        end
        // countdown loop
        v[0].prog[0] = enc(9, 0, 0, 8'd5);  v[0].prog[1] = enc(13, 0, 0, 8'd1);
        v[0].prog[2] = enc(3, 0, 0, 8'hFF); v[0].prog[3] = enc(1, 0, 0, 0);
        v[0].z = 1; v[0].c = 1; v[0].pc = 3; v[0].ret = 12;
        // add carry-out, jc taken
        v[1].prog[0] = enc(9, 0, 1, 8'hF0); v[1].prog[1] = enc(11, 0, 1, 8'h20);
        v[1].prog[2] = enc(4, 0, 0, 8'd2);  v[1].prog[3] = enc(9, 0, 2, 8'd1);
        v[1].r[1] = 8'h10; v[1].z = 0; v[1].c = 1; v[1].pc = 4; v[1].ret = 4;
        // cmpi with borrow
        v[2].prog[0] = enc(9, 0, 2, 8'd3);  v[2].prog[1] = enc(15, 0, 2, 8'd5);
        v[2].r[2] = 8'd3; v[2].z = 0; v[2].c = 0; v[2].pc = 2; v[2].ret = 3;
        // cmpi equal, mov keeps flags
        v[3].prog[0] = enc(9, 0, 2, 8'd3);  v[3].prog[1] = enc(15, 0, 2, 8'd5);
        v[3].prog[2] = enc(15, 0, 2, 8'd3); v[3].prog[3] = enc(8, 2, 3, 0);
        v[3].r[2] = 8'd3; v[3].r[3] = 8'd3; v[3].z = 1; v[3].c = 1; v[3].pc = 4; v[3].ret = 5;
        // src==dst add doubles, sub clears
        v[4].prog[0] = enc(9, 0, 1, 8'h81); v[4].prog[1] = enc(10, 1, 1, 0);
        v[4].prog[2] = enc(8, 1, 0, 0);     v[4].prog[3] = enc(12, 1, 1, 0);
        v[4].r[0] = 8'h02; v[4].z = 1; v[4].c = 1; v[4].pc = 4; v[4].ret = 5;
        // register sub with borrow, jc not taken
        v[5].prog[0] = enc(9, 0, 0, 8'd1);  v[5].prog[1] = enc(9, 0, 1, 8'd2);
        v[5].prog[2] = enc(12, 1, 0, 0);    v[5].prog[3] = enc(4, 0, 0, 8'd2);
        v[5].prog[4] = enc(9, 0, 3, 8'd7);
        v[5].r[0] = 8'hFF; v[5].r[1] = 8'd2; v[5].r[3] = 8'd7;
        v[5].z = 0; v[5].c = 0; v[5].pc = 5; v[5].ret = 6;
        // jmp, cmpi zero, jz taken, unused opcode as nop
        v[6].prog[0] = enc(0, 0, 0, 8'd2);  v[6].prog[1] = enc(9, 0, 3, 8'd9);
        v[6].prog[2] = enc(15, 0, 0, 8'd0); v[6].prog[3] = enc(2, 0, 0, 8'd2);
        v[6].prog[4] = enc(9, 0, 3, 8'd8);  v[6].prog[5] = enc(7, 0, 3, 8'd4);
        v[6].z = 1; v[6].c = 1; v[6].pc = 6; v[6].ret = 5;

        // reset state
        tick(); tick();
        chk("rst_pc", pc, 0);
        chk("rst_z", zflag, 0);
        chk("rst_c", cflag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retired", retired, 0);
        chk("rst_r0", dbg_rdata, 0);
        rst_n = 1'b1;
        tick();

        // table of programs
        for (int i = 0; i < 7; i++) begin
            doReset();
            load(v[i].prog);
            start = 1'b1; tick(); start = 1'b0;
            n = 0;
            waitHalt(n);
            checkResult($sformatf("vec%0d", i), v[i], n);
        end

        // prog_we and start while busy are ignored
        doReset();
        load(v[0].prog);
        start = 1'b1; tick();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            prog_we = 1'b1; prog_addr = 5'(1 + k % 3); prog_wdata = enc(9, 0, 3, 8'h55);
            tick(); n++;
        end
        prog_we = 1'b0; start = 1'b0;
        waitHalt(n);
        checkResult("busywr", v[0], n);

        // reset during EXEC of addi
        doReset();
        load(v[1].prog);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        dbg_raddr = 2'd1; #1;
        chk("midexec_busy", busy, 1'b1);
        chk("midexec_r1_pre", dbg_rdata, 8'hF0);
        rst_n = 1'b0; #2;
        chk("midrst_pc", pc, 0);
        chk("midrst_r1", dbg_rdata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_retired", retired, 0);
        chk("midrst_c", cflag, 0);
        tick(); rst_n = 1'b1; tick();
        chk("midrst_idle_busy", busy, 0);
        chk("midrst_idle_halted", halted, 0);
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        waitHalt(n);
        checkResult("rerun", v[1], n);

        // 32 nops: pc wrap and retired saturation on the narrow copy
        doReset();
        for (int k = 0; k < 32; k++) begin
            prog_we = 1'b1; prog_addr = 5'(k); prog_wdata = 16'h5000;
            tick();
        end
        prog_we = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 62; k++) tick();
        chk("wrap_pc31", pc, 31);
        tick(); tick();
        chk("wrap_pc0", pc, 0);
        chk("wrap_ret32", retired, 32);
        chk("wrap_busy", busy, 1'b1);
        chk("sat_ret15", retiredS, 15);
        for (int k = 0; k < 6; k++) tick();
        chk("wrap_pc3", pc, 3);
        chk("wrap_ret35", retired, 35);
        chk("wrap_halted", halted, 0);
        chk("sat_ret15_hold", retiredS, 15);
        chk("sat_busy", busyS, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
